display_scan_driver: RTL and testbench



---
 rtl/display_scan_driver_if.sv | 19 +
 rtl/display_scan_driver.sv | 127 ++++++++++++
 tb/tb_display_scan_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_driver_if.sv
// rtl/display_scan_driver_if.sv - frame load bus between core and display scan driver
interface display_scan_driver_if;
    logic        load;
    logic [39:0] digits;
    logic [7:0]  en_mask;
    logic [7:0]  blink_mask;
    logic [7:0]  dp_mask;
    logic        applied;

    modport master (
        output load, digits, en_mask, blink_mask, dp_mask,
        input  applied
    );

    modport slave (
        input  load, digits, en_mask, blink_mask, dp_mask,
        output applied
    );
endinterface

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - eight-digit seven-segment scanner with tear-free frame apply and blink
module display_scan_driver #(
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 50000000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    display_scan_driver_if.slave        frame,
    output logic [7:0]                  seg_out,
    output logic [7:0]                  an
);
    localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [7:0] OUT_POL = {8{ACTIVE_LOW}};

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic [2:0]    idx;
    logic          blink_phase;

    logic [39:0]   act_digits, pend_digits;
    logic [7:0]    act_en, act_blink, act_dp;
    logic [7:0]    pend_en, pend_blink, pend_dp;
    logic          pend_valid;

    logic          scan_term, blink_term, boundary, dark;
    logic [4:0]    code;
    logic [6:0]    glyph;
    logic [7:0]    seg_next, an_next;

    always_comb begin
        scan_term  = (scan_cnt == SW'(SCAN_DIV - 1));
        blink_term = (blink_cnt == BW'(BLINK_DIV - 1));
        boundary   = scan_term && (idx == 3'd7);
        code       = act_digits[idx*5 +: 5];
        dark       = !act_en[idx] || (act_blink[idx] && blink_phase);
    end

    always_comb begin
        glyph = 7'h00;
        case (code)
            5'd0:  glyph = 7'h3F;
            5'd1:  glyph = 7'h06;
            5'd2:  glyph = 7'h5B;
            5'd3:  glyph = 7'h4F;
            5'd4:  glyph = 7'h66;
            5'd5:  glyph = 7'h6D;
            5'd6:  glyph = 7'h7D;
            5'd7:  glyph = 7'h07;
            5'd8:  glyph = 7'h7F;
            5'd9:  glyph = 7'h6F;
            5'd10: glyph = 7'h77;
            5'd11: glyph = 7'h7C;
            5'd12: glyph = 7'h39;
            5'd13: glyph = 7'h5E;
            5'd14: glyph = 7'h79;
            5'd15: glyph = 7'h71;
            5'd17: glyph = 7'h40;
            5'd18: glyph = 7'h76;
            5'd19: glyph = 7'h38;
            5'd20: glyph = 7'h73;
            5'd21: glyph = 7'h3E;
            5'd22: glyph = 7'h50;
            5'd23: glyph = 7'h5C;
            default: glyph = 7'h00;
        endcase
    end

    always_comb begin
        seg_next = 8'h00;
        an_next  = 8'h00;
        if (!dark) begin
            seg_next = {act_dp[idx], glyph};
            an_next  = 8'b1 << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt      <= '0;
            blink_cnt     <= '0;
            idx           <= 3'd0;
            blink_phase   <= 1'b0;
            act_digits    <= 40'd0;
            act_en        <= 8'd0;
            act_blink     <= 8'd0;
            act_dp        <= 8'd0;
            pend_digits   <= 40'd0;
            pend_en       <= 8'd0;
            pend_blink    <= 8'd0;
            pend_dp       <= 8'd0;
            pend_valid    <= 1'b0;
            frame.applied <= 1'b0;
            seg_out       <= OUT_POL;
            an            <= OUT_POL;
        end else begin
            scan_cnt  <= scan_term  ? '0 : scan_cnt + SW'(1);
            blink_cnt <= blink_term ? '0 : blink_cnt + BW'(1);
            if (scan_term)
                idx <= idx + 3'd1;
            if (blink_term)
                blink_phase <= !blink_phase;

            // Boundary takes the older pending frame; a same-cycle load stays queued.
            frame.applied <= boundary && pend_valid;
            if (boundary && pend_valid) begin
                act_digits <= pend_digits;
                act_en     <= pend_en;
                act_blink  <= pend_blink;
                act_dp     <= pend_dp;
            end
            if (frame.load) begin
                pend_digits <= frame.digits;
                pend_en     <= frame.en_mask;
                pend_blink  <= frame.blink_mask;
                pend_dp     <= frame.dp_mask;
                pend_valid  <= 1'b1;
            end else if (boundary) begin
                pend_valid  <= 1'b0;
            end

            seg_out <= seg_next ^ OUT_POL;
            an      <= an_next  ^ OUT_POL;
        end
    end
endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - randomized bench for display_scan_driver against a time-based reference model
module tb_display_scan_driver;
    localparam int SCAN  = 4;
    localparam int BLINK = 16;
    localparam int FRAME = 8 * SCAN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scan_driver_if fi0 ();
    display_scan_driver_if fi1 ();
    logic [7:0] seg0, an0, seg1, an1;

    display_scan_driver #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .frame(fi0), .seg_out(seg0), .an(an0)
    );
    display_scan_driver #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .frame(fi1), .seg_out(seg1), .an(an1)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [6:0]  glyph_tab [32];
    logic [39:0] m_act_d, m_pen_d;
    logic [7:0]  m_act_en, m_act_bl, m_act_dp;
    logic [7:0]  m_pen_en, m_pen_bl, m_pen_dp;
    bit          m_pv;
    int          t;

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
        end
    endtask

    task automatic drive(input bit ld, input logic [39:0] d, input logic [7:0] en, input logic [7:0] bl,
                         input logic [7:0] dp);
        fi0.load = ld; fi0.digits = d; fi0.en_mask = en; fi0.blink_mask = bl; fi0.dp_mask = dp;
        fi1.load = ld; fi1.digits = d; fi1.en_mask = en; fi1.blink_mask = bl; fi1.dp_mask = dp;
    endtask

    // One post-reset cycle: digit slot and blink phase follow directly from elapsed time t.
    task automatic step(input bit ld, input logic [39:0] d, input logic [7:0] en, input logic [7:0] bl,
                        input logic [7:0] dp);
        int         idx;
        bit         ph, dark, e_app;
        logic [7:0] e_seg, e_an;
        @(negedge clk);
        rst = 1'b0;
        drive(ld, d, en, bl, dp);
        idx   = (t / SCAN) % 8;
        ph    = ((t / BLINK) % 2) == 1;
        dark  = !m_act_en[idx] || (m_act_bl[idx] && ph);
        e_an  = dark ? 8'h00 : (8'b1 << idx);
        e_seg = dark ? 8'h00 : {m_act_dp[idx], glyph_tab[m_act_d[idx*5 +: 5]]};
        e_app = ((t % FRAME) == FRAME - 1) && m_pv;
        if (e_app) begin
            m_act_d = m_pen_d; m_act_en = m_pen_en; m_act_bl = m_pen_bl; m_act_dp = m_pen_dp;
            m_pv = 0;
        end
        if (ld) begin
            m_pen_d = d; m_pen_en = en; m_pen_bl = bl; m_pen_dp = dp;
            m_pv = 1;
        end
        t++;
        @(posedge clk);
        #1;
        if (fi0.applied) pulses++;
        check_eq("seg_hi", {32'd0, seg0}, {32'd0, e_seg});
        check_eq("an_hi", {32'd0, an0}, {32'd0, e_an});
        check_eq("applied_hi", {39'd0, fi0.applied}, {39'd0, e_app});
        check_eq("seg_lo", {32'd0, seg1}, {32'd0, ~e_seg});
        check_eq("an_lo", {32'd0, an1}, {32'd0, ~e_an});
        check_eq("applied_lo", {39'd0, fi1.applied}, {39'd0, e_app});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 40'd0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 40'd0, 8'h00, 8'h00, 8'h00);
        repeat (n) @(posedge clk);
        #1;
        check_eq("rst_seg_hi", {32'd0, seg0}, 40'h00);
        check_eq("rst_an_hi", {32'd0, an0}, 40'h00);
        check_eq("rst_app_hi", {39'd0, fi0.applied}, 40'h0);
        check_eq("rst_seg_lo", {32'd0, seg1}, 40'hFF);
        check_eq("rst_an_lo", {32'd0, an1}, 40'hFF);
        m_act_d = '0; m_act_en = '0; m_act_bl = '0; m_act_dp = '0;
        m_pen_d = '0; m_pen_en = '0; m_pen_bl = '0; m_pen_dp = '0;
        m_pv = 0;
        t = 0;
    endtask

    logic [39:0] base_d, d03, d12, rd;

    initial begin
        glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                      7'h00, 7'h40, 7'h76, 7'h38, 7'h73, 7'h3E, 7'h50, 7'h5C,
                      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        t = 0;
        rst = 1'b1;
        drive(1'b0, 40'd0, 8'h00, 8'h00, 8'h00);
        base_d = {{6{5'h10}}, 5'h0A, 5'h01};
        d03    = {{6{5'h10}}, 5'h0A, 5'h03};
        d12    = {{6{5'h10}}, 5'h0A, 5'h12};

        do_reset(3);
        pulses = 0;
        idle(100);
        check_eq("idle_pulses", 40'(pulses), 40'd0);

        do_reset(1);
        pulses = 0;
        idle(1);
        step(1'b1, base_d, 8'hFF, 8'h00, 8'h02);
        idle(70);
        check_eq("first_frame_pulses", 40'(pulses), 40'd1);

        do_reset(1);
        idle(1);
        step(1'b1, base_d, 8'hFF, 8'h01, 8'h02);
        idle(90);

        do_reset(1);
        pulses = 0;
        idle(1);
        step(1'b1, d03, 8'hFF, 8'h00, 8'h00);
        idle(5);
        step(1'b1, d12, 8'hFF, 8'h00, 8'h00);
        idle(60);
        check_eq("double_load_pulses", 40'(pulses), 40'd1);

        do_reset(1);
        pulses = 0;
        idle(5);
        step(1'b1, d03, 8'hFF, 8'h00, 8'h01);
        idle(FRAME - 1 - 6);
        step(1'b1, d12, 8'hFF, 8'h00, 8'h80);
        idle(70);
        check_eq("boundary_load_pulses", 40'(pulses), 40'd2);

        idle(10);
        step(1'b1, base_d, 8'hFF, 8'h00, 8'h00);
        idle(3);
        do_reset(1);
        pulses = 0;
        idle(40);
        check_eq("post_reset_pulses", 40'(pulses), 40'd0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1);
            rd[31:0]  = $urandom();
            rd[39:32] = 8'($urandom());
            step($urandom_range(0, 11) == 0, rd, 8'($urandom()), 8'($urandom()), 8'($urandom()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
